// File: rtl/fpu_unpack_stage.sv
// fpu_unpack_stage: two-stage NaN-box check, widen and classify of an FPU register operand
module fpu_unpack_stage #(
    parameter int FLEN = 64,
    parameter int NE   = 11,
    parameter int NF   = 52,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [FLEN-1:0] X,
    input  logic [1:0]      Fmt,
    input  logic [TAGW-1:0] Tag,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [FLEN-1:0] Unpacked,
    output logic [1:0]      OutFmt,
    output logic [TAGW-1:0] OutTag,
    output logic            XZero,
    output logic            XSubnorm,
    output logic            XInf,
    output logic            XNaN,
    output logic            XSNaN,
    output logic            BoxErr,
    output logic            FmtErr
);
    localparam logic [FLEN-1:0] QNAN = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};

    logic            v1, v2, b1, adv2, take, boxed;
    logic [FLEN-1:0] x1, wide_s, wide_h, u;
    logic [1:0]      f1;
    logic [TAGW-1:0] t1;
    logic [7:0]      es;
    logic [4:0]      eh;
    logic [NE-1:0]   es_w, eh_w, ue;
    logic [NF-1:0]   uf;

    assign adv2     = !v2 | OutReady;
    assign InReady  = !v1 | adv2;
    assign take     = InValid & InReady & !Flush;
    assign OutValid = v2;

    // Boxing check on the incoming operand: upper bits above the narrow width must be all ones
    always_comb begin
        boxed = (Fmt == 2'b00) ? &X[FLEN-1:32] : (Fmt == 2'b10) ? &X[FLEN-1:16] : 1'b1;
    end

    // Stage-2 datapath: rebias narrow exponents, left-align fractions, substitute qNaN on errors
    always_comb begin
        es     = x1[30:23];
        eh     = x1[14:10];
        es_w   = (es == '0) ? '0 : (&es) ? '1 : {es[7], {(NE-8){~es[7]}}, es[6:0]};
        eh_w   = (eh == '0) ? '0 : (&eh) ? '1 : {eh[4], {(NE-5){~eh[4]}}, eh[3:0]};
        wide_s = {x1[31], es_w, x1[22:0], {(NF-23){1'b0}}};
        wide_h = {x1[15], eh_w, x1[9:0], {(NF-10){1'b0}}};
        u      = (f1 == 2'b01) ? x1 : ((f1 == 2'b11) || !b1) ? QNAN : (f1 == 2'b00) ? wide_s : wide_h;
        ue     = u[FLEN-2:NF];
        uf     = u[NF-1:0];
    end

    // Pipeline occupancy; flush empties both stages and blocks the same-cycle input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (Flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= take ? 1'b1 : adv2 ? 1'b0 : v1;
            v2 <= adv2 ? v1 : v2;
        end
    end

    // Stage-1 capture of the raw operand and its boxing status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1 <= '0;
            f1 <= '0;
            t1 <= '0;
            b1 <= 1'b0;
        end else if (take) begin
            x1 <= X;
            f1 <= Fmt;
            t1 <= Tag;
            b1 <= boxed;
        end
    end

    // Stage-2 capture of the widened operand and its class; holds while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Unpacked <= '0;
            OutFmt   <= '0;
            OutTag   <= '0;
            XZero    <= 1'b0;
            XSubnorm <= 1'b0;
            XInf     <= 1'b0;
            XNaN     <= 1'b0;
            XSNaN    <= 1'b0;
            BoxErr   <= 1'b0;
            FmtErr   <= 1'b0;
        end else if (adv2 && v1) begin
            Unpacked <= u;
            OutFmt   <= f1;
            OutTag   <= t1;
            XZero    <= (ue == '0) && (uf == '0);
            XSubnorm <= (ue == '0) && (uf != '0);
            XInf     <= (&ue) && (uf == '0);
            XNaN     <= (&ue) && (uf != '0);
            XSNaN    <= (&ue) && (uf != '0) && !uf[NF-1];
            BoxErr   <= !b1;
            FmtErr   <= (f1 == 2'b11);
        end
    end
endmodule

// File: tb/tb_fpu_unpack_stage.sv
// tb_fpu_unpack_stage: directed checks of widening, classification, backpressure, flush and reset
module tb_fpu_unpack_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        InValid = 1'b0, OutReady = 1'b1, Flush = 1'b0;
    logic        InReady, OutValid;
    logic [63:0] X = '0, Unpacked;
    logic [1:0]  Fmt = '0, OutFmt;
    logic [3:0]  Tag = '0, OutTag;
    logic        XZero, XSubnorm, XInf, XNaN, XSNaN, BoxErr, FmtErr;
    logic [6:0]  flags;
    int          checks = 0, errors = 0;

    assign flags = {XZero, XSubnorm, XInf, XNaN, XSNaN, BoxErr, FmtErr};

    fpu_unpack_stage dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .X(X), .Fmt(Fmt),
        .Tag(Tag), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .Unpacked(Unpacked),
        .OutFmt(OutFmt), .OutTag(OutTag), .XZero(XZero), .XSubnorm(XSubnorm), .XInf(XInf),
        .XNaN(XNaN), .XSNaN(XSNaN), .BoxErr(BoxErr), .FmtErr(FmtErr)
    );

    always #5 clk = ~clk;

    // flags order: Zero Subnorm Inf NaN SNaN BoxErr FmtErr
    logic [63:0] vx [12] = '{64'hFFFF_FFFF_3F80_0000, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_FFFF_3C00,
                            64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_0000_0001, 64'h8000_0000_0000_0000,
                            64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_0000_3C00, 64'hFFFF_FFFF_FF80_0000,
                            64'hFFFF_FFFF_FFFF_C000, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_FFFF_0001};
    logic [1:0]  vf [12] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    logic [63:0] vu [12] = '{64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                            64'h7FF0_0000_2000_0000, 64'h0000_0000_2000_0000, 64'h8000_0000_0000_0000,
                            64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                            64'hC000_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h0000_0400_0000_0000};
    logic [6:0]  vc [12] = '{7'b0000000, 7'b0001010, 7'b0000000, 7'b0001100, 7'b0100000, 7'b1000000,
                            7'b0001001, 7'b0001010, 7'b0010000, 7'b0000000, 7'b0001000, 7'b0100000};

    task test_reset;
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: OutValid=%b InReady=%b, required 0 1", OutValid, InReady);
        end
        checks++;
        if (Unpacked !== 64'h0 || flags !== 7'h0 || OutTag !== 4'h0 || OutFmt !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: Unpacked=%h flags=%b tag=%h fmt=%b, required all zero", Unpacked, flags, OutTag, OutFmt);
        end
        reset = 1'b0;
    endtask

    task test_vectors;
        OutReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            InValid = 1'b1; X = vx[i]; Fmt = vf[i]; Tag = 4'(i);
            @(negedge clk);
            InValid = 1'b0;
            checks++;
            if (OutValid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early: OutValid=%b, required 0", i, OutValid);
            end
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b1 || Unpacked !== vu[i] || flags !== vc[i] || OutTag !== 4'(i) || OutFmt !== vf[i]) begin
                errors++;
                $display("FAIL vec%0d: valid=%b Unpacked=%h flags=%b tag=%h fmt=%b, required 1 %h %b %h %b",
                         i, OutValid, Unpacked, flags, OutTag, OutFmt, vu[i], vc[i], 4'(i), vf[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL vec_drain: OutValid=%b, required 0", OutValid);
        end
    endtask

    task test_back_to_back;
        int idx [5];
        int sent, recv, cyc;
        logic acc, out;
        idx = '{0, 2, 8, 9, 11};
        sent = 0; recv = 0; cyc = 0;
        while (recv < 5 && cyc < 40) begin
            @(negedge clk);
            InValid = (sent < 5);
            if (sent < 5) begin X = vx[idx[sent]]; Fmt = vf[idx[sent]]; Tag = 4'(sent + 1); end
            OutReady = (cyc >= 4);
            #1;
            acc = InValid & InReady;
            out = OutValid & OutReady;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (InReady !== 1'b0 || sent !== 2) begin
                    errors++;
                    $display("FAIL b2b_stall%0d: InReady=%b accepted=%0d, required 0 2", cyc, InReady, sent);
                end
                checks++;
                if (OutValid !== 1'b1 || OutTag !== 4'd1 || Unpacked !== vu[0]) begin
                    errors++;
                    $display("FAIL b2b_hold%0d: valid=%b tag=%h Unpacked=%h, required 1 1 %h", cyc, OutValid, OutTag, Unpacked, vu[0]);
                end
            end
            if (out) begin
                checks++;
                if (OutTag !== 4'(recv + 1) || Unpacked !== vu[idx[recv]] || flags !== vc[idx[recv]]) begin
                    errors++;
                    $display("FAIL b2b_out%0d: tag=%h Unpacked=%h flags=%b, required %h %h %b",
                             recv, OutTag, Unpacked, flags, 4'(recv + 1), vu[idx[recv]], vc[idx[recv]]);
                end
            end
            @(posedge clk);
            if (acc) sent++;
            if (out) recv++;
            cyc++;
        end
        @(negedge clk);
        InValid = 1'b0;
        OutReady = 1'b1;
        checks++;
        if (recv !== 5) begin
            errors++;
            $display("FAIL b2b_count: received=%0d, required 5", recv);
        end
    endtask

    task load_two;
        OutReady = 1'b0;
        @(negedge clk);
        InValid = 1'b1; X = vx[0]; Fmt = vf[0]; Tag = 4'd6;
        @(negedge clk);
        X = vx[2]; Fmt = vf[2]; Tag = 4'd7;
        @(negedge clk);
        InValid = 1'b0;
    endtask

    task send_after(input string nm);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle%0d: OutValid=%b, required 0", nm, i, OutValid);
            end
        end
        InValid = 1'b1; X = vx[3]; Fmt = vf[3]; Tag = 4'd9;
        @(negedge clk);
        InValid = 1'b0;
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b1 || OutTag !== 4'd9 || Unpacked !== vu[3] || flags !== vc[3]) begin
            errors++;
            $display("FAIL %s_next: valid=%b tag=%h Unpacked=%h flags=%b, required 1 9 %h %b",
                     nm, OutValid, OutTag, Unpacked, flags, vu[3], vc[3]);
        end
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_alone: OutValid=%b, required 0", nm, OutValid);
        end
    endtask

    task test_flush;
        load_two();
        checks++;
        if (OutValid !== 1'b1) begin
            errors++;
            $display("FAIL flush_loaded: OutValid=%b, required 1", OutValid);
        end
        OutReady = 1'b1;
        Flush = 1'b1; InValid = 1'b1; X = vx[5]; Fmt = vf[5]; Tag = 4'd8;
        @(negedge clk);
        Flush = 1'b0; InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_out: OutValid=%b, required 0", OutValid);
        end
        send_after("flush");
    endtask

    task test_midreset;
        load_two();
        OutReady = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: OutValid=%b InReady=%b, required 0 1", OutValid, InReady);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b0 || Unpacked !== 64'h0) begin
            errors++;
            $display("FAIL rst_out: OutValid=%b Unpacked=%h, required 0 0", OutValid, Unpacked);
        end
        send_after("rst");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
